// File: rtl/fs_rx_pkg.sv
// Shared constants, state encoding and width helper for the FS word receiver.
package fs_rx_pkg;

  localparam int FS_WORD_WIDTH = 32;
  localparam int FS_CNT_W      = $clog2(FS_WORD_WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCHED = 2'd2
  } fsRxState_t;

  // Counter must hold 0..width+1 so an over-length frame stays distinguishable.
  function automatic int fsCntWidth(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/fs_rx_sync_filter.sv
// 2-flop synchronizer, optional run-length glitch filter (FS_RX_GLITCH_FILTER_EN)
// and previous-value register producing an aligned level and rise pulse.
module fs_rx_sync_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clkIN,
  input  logic nResetIN,
  input  logic sigIN,
  output logic levelOUT,
  output logic riseOUT
);

  logic sync1;
  logic sync2;
  logic cond;

  if (FILTER_LEN < 1) begin : gBadLen
    $error("FILTER_LEN must be at least 1");
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sigIN;
      sync2 <= sync1;
    end
  end

`ifdef FS_RX_GLITCH_FILTER_EN
  localparam int FcW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FcW-1:0] runCnt;
  logic           filt;

  // The FILTER_LEN-th consecutive differing sample commits the new level.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      runCnt <= '0;
      filt   <= 1'b0;
    end else if (sync2 == filt) begin
      runCnt <= '0;
    end else if (runCnt == FcW'(FILTER_LEN - 1)) begin
      runCnt <= '0;
      filt   <= sync2;
    end else begin
      runCnt <= runCnt + 1'b1;
    end
  end

  assign cond = filt;
`else
  assign cond = sync2;
`endif

  // levelOUT doubles as the previous-value register, keeping level and rise aligned.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      levelOUT <= 1'b0;
      riseOUT  <= 1'b0;
    end else begin
      levelOUT <= cond;
      riseOUT  <= cond & ~levelOUT;
    end
  end

endmodule

// File: rtl/fs_word_receiver.sv
// Serial CLK/DATA/LE word receiver: LSB-first shift, length check on LE rise.
// Optional input glitch filter enabled by defining FS_RX_GLITCH_FILTER_EN.
module fs_word_receiver
  import fs_rx_pkg::*;
#(
  parameter int WIDTH      = FS_WORD_WIDTH,
  parameter int FILTER_LEN = 3
) (
  input  logic             clkIN,
  input  logic             nResetIN,
  input  logic             fsClkIN,
  input  logic             fsDataIN,
  input  logic             fsLeIN,
  output logic [WIDTH-1:0] dataOUT,
  output logic             validOUT,
  output logic             errOUT,
  output logic             busyOUT
);

  localparam int CntW = fsCntWidth(WIDTH);
  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntSat  = CntW'(WIDTH + 1);

  logic unusedClkLvl;
  logic unusedDatRise;
  logic clkRise;
  logic datLvl;
  logic leLvl;
  logic leRise;

  fs_rx_sync_filter #(.FILTER_LEN(FILTER_LEN)) uClk (
    .clkIN(clkIN), .nResetIN(nResetIN), .sigIN(fsClkIN),
    .levelOUT(unusedClkLvl), .riseOUT(clkRise)
  );

  fs_rx_sync_filter #(.FILTER_LEN(FILTER_LEN)) uData (
    .clkIN(clkIN), .nResetIN(nResetIN), .sigIN(fsDataIN),
    .levelOUT(datLvl), .riseOUT(unusedDatRise)
  );

  fs_rx_sync_filter #(.FILTER_LEN(FILTER_LEN)) uLe (
    .clkIN(clkIN), .nResetIN(nResetIN), .sigIN(fsLeIN),
    .levelOUT(leLvl), .riseOUT(leRise)
  );

  fsRxState_t       state;
  fsRxState_t       nextState;
  logic [CntW-1:0]  cnt;
  logic [CntW-1:0]  cntPost;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shregPost;
  logic             shiftEn;
  logic             validNext;
  logic             errNext;

  // A clock edge coinciding with the LE edge still shifts; the length check sees it.
  assign shiftEn   = clkRise & (~leLvl | leRise);
  assign shregPost = shiftEn ? {datLvl, shreg[WIDTH-1:1]} : shreg;

  always_comb begin
    cntPost = cnt;
    if (shiftEn && (cnt != CntSat)) begin
      cntPost = cnt + 1'b1;
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (leRise) begin
          nextState = LATCHED;
        end else if (shiftEn) begin
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (leRise) begin
          nextState = LATCHED;
        end
      end
      LATCHED: begin
        if (!leLvl) begin
          nextState = shiftEn ? SHIFT : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    validNext = 1'b0;
    errNext   = 1'b0;
    if (leRise && (state != LATCHED)) begin
      validNext = (cntPost == CntFull);
      errNext   = (cntPost != '0) && (cntPost != CntFull);
    end
  end

  // Shift register carries no reset: it is only published after WIDTH fresh bits.
  always_ff @(posedge clkIN) begin
    shreg <= shregPost;
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      cnt      <= '0;
      dataOUT  <= '0;
      validOUT <= 1'b0;
      errOUT   <= 1'b0;
    end else begin
      cnt      <= leRise ? '0 : cntPost;
      validOUT <= validNext;
      errOUT   <= errNext;
      if (validNext) begin
        dataOUT <= shregPost;
      end
    end
  end

  assign busyOUT = (cnt != '0) & ~leLvl;

endmodule

// File: tb/tb_fs_word_receiver.sv
// Randomized bench for fs_word_receiver with a frame-level expectation model.
module tb_fs_word_receiver;

  localparam int FL = 3;
`ifdef FS_RX_GLITCH_FILTER_EN
  localparam int HMIN = FL + 2;
  localparam int LAT  = FL + 5;
`else
  localparam int HMIN = 2;
  localparam int LAT  = 5;
`endif
  localparam int H = HMIN + 1;

  logic        clkIN;
  logic        nResetIN;
  logic        fsClkIN;
  logic        fsDataIN;
  logic        fsLeIN;
  logic [31:0] dataOUT;
  logic        validOUT;
  logic        errOUT;
  logic        busyOUT;

  fs_word_receiver #(.WIDTH(32), .FILTER_LEN(FL)) dut (
    .clkIN(clkIN), .nResetIN(nResetIN), .fsClkIN(fsClkIN), .fsDataIN(fsDataIN),
    .fsLeIN(fsLeIN), .dataOUT(dataOUT), .validOUT(validOUT), .errOUT(errOUT),
    .busyOUT(busyOUT)
  );

  typedef struct {
    bit          isErr;
    logic [31:0] word;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] lastGood;
  int          checks;
  int          errors;

  initial begin
    clkIN = 1'b0;
    forever #5 clkIN = ~clkIN;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time bound, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset: pulses must match the expected frame outcomes in order,
  // and dataOUT must hold the last accepted word otherwise.
  always @(negedge clkIN) begin
    exp_t e;
    if (nResetIN) begin
      if (validOUT || errOUT) begin
        chk("pulseExcl", {31'b0, validOUT & errOUT}, 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedPulse: got valid=%0b err=%0b required no pulse at %0t",
                   validOUT, errOUT, $time);
        end else begin
          e = expQ.pop_front();
          chk("pulseIsErr", {31'b0, errOUT}, {31'b0, e.isErr});
          if (!e.isErr) begin
            chk("pulseData", dataOUT, e.word);
            lastGood = e.word;
          end
        end
      end else begin
        chk("dataHold", dataOUT, lastGood);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clkIN);
    #1;
  endtask

  task automatic sendBit(input bit b, input int h, input bit glitch);
    fsDataIN = b;
    if (glitch) begin
      cyc(2);
      fsClkIN = 1'b1;
      cyc(1);
      fsClkIN = 1'b0;
    end
    cyc(h);
    fsClkIN = 1'b1;
    cyc(h);
    fsClkIN = 1'b0;
  endtask

  task automatic expectFrame(input int nbits, input logic [31:0] w, input bit forceErr);
    exp_t e;
    e.word = w;
    e.isErr = forceErr || (nbits != 32);
    if (nbits != 0) expQ.push_back(e);
  endtask

  task automatic leOnly(input int h);
    fsLeIN = 1'b1;
    cyc(h);
    fsLeIN = 1'b0;
    cyc(h);
  endtask

  task automatic sendFrame(input logic [31:0] w, input int nbits, input int h);
    for (int i = 0; i < nbits; i++) begin
      sendBit((i < 32) ? w[i] : 1'($urandom), h, 1'b0);
    end
    expectFrame(nbits, w, 1'b0);
    leOnly(h);
  endtask

  task automatic doReset();
    nResetIN = 1'b0;
    expQ.delete();
    lastGood = '0;
    @(negedge clkIN);
    chk("rstData", dataOUT, 32'd0);
    chk("rstValid", {31'b0, validOUT}, 32'd0);
    chk("rstErr", {31'b0, errOUT}, 32'd0);
    chk("rstBusy", {31'b0, busyOUT}, 32'd0);
    cyc(2);
    nResetIN = 1'b1;
    cyc(2);
  endtask

  initial begin
    logic [31:0] w;
    int          nb;
    int          h;
    int          r;
    checks   = 0;
    errors   = 0;
    lastGood = '0;
    nResetIN = 1'b0;
    fsClkIN  = 1'b0;
    fsDataIN = 1'b0;
    fsLeIN   = 1'b0;
    cyc(3);
    doReset();

    sendFrame(32'h0000_0010, 32, H);
    cyc(LAT);
    chk("frame10", dataOUT, 32'h0000_0010);

    sendFrame(32'h0BAD_F00D, 31, H);
    cyc(LAT);
    chk("short31Hold", dataOUT, 32'h0000_0010);
    sendFrame(32'h0BAD_F00D, 33, H);
    cyc(LAT);
    chk("long33Hold", dataOUT, 32'h0000_0010);

    sendFrame(32'hFFFF_FFFF, 32, HMIN);
    sendFrame(32'h0000_0001, 32, HMIN);
    cyc(LAT);
    chk("backToBack", dataOUT, 32'h0000_0001);

    for (int i = 0; i < 16; i++) sendBit(1'($urandom), H, 1'b0);
    cyc(LAT);
    chk("busyMid", {31'b0, busyOUT}, 32'd1);
    doReset();
    sendFrame(32'hA5A5_5A5A, 32, H);
    cyc(LAT);
    chk("afterReset", dataOUT, 32'hA5A5_5A5A);
    chk("busyIdle", {31'b0, busyOUT}, 32'd0);

    fsLeIN = 1'b1;
    doReset();
    cyc(H);
    for (int i = 0; i < 3; i++) sendBit(1'b1, H, 1'b0);
    fsLeIN = 1'b0;
    cyc(H + LAT);
    chk("leHighNoShift", {31'b0, busyOUT}, 32'd0);
    sendFrame(32'h3C3C_0FF0, 32, H);
    cyc(LAT);
    chk("afterLeHigh", dataOUT, 32'h3C3C_0FF0);

    w = 32'h1234_5678;
    for (int i = 0; i < 32; i++) sendBit(w[i], H, i == 10);
`ifdef FS_RX_GLITCH_FILTER_EN
    expectFrame(32, w, 1'b0);
`else
    expectFrame(32, w, 1'b1);
`endif
    leOnly(H);
    cyc(LAT);
`ifdef FS_RX_GLITCH_FILTER_EN
    chk("glitchFiltered", dataOUT, 32'h1234_5678);
`else
    chk("glitchErrHold", dataOUT, 32'h3C3C_0FF0);
`endif

    // Last clock rise coincides with the LE rise: still a full-length frame.
    w = $urandom;
    for (int i = 0; i < 31; i++) sendBit(w[i], H, 1'b0);
    fsDataIN = w[31];
    cyc(H);
    expectFrame(32, w, 1'b0);
    fsClkIN = 1'b1;
    fsLeIN  = 1'b1;
    cyc(H);
    fsClkIN = 1'b0;
    cyc(H);
    fsLeIN = 1'b0;
    cyc(H + LAT);
    chk("simultaneous", dataOUT, w);

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) nb = 32;
      else if (r == 6) nb = 0;
      else if (r == 7) nb = 31;
      else if (r == 8) nb = 33;
      else nb = $urandom_range(1, 40);
      h = $urandom_range(HMIN, HMIN + 2);
      sendFrame($urandom, nb, h);
    end
    cyc(LAT + 4);
    chk("queueDrained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
